// File: rtl/data_sram_bridge.sv
// Bridges the core's single-cycle data port onto a request/addr-ok/data-ok bus with one
// outstanding transaction, stalling the core until it finishes; a watchdog aborts hung accesses.
module data_sram_bridge #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic [3:0]  cpu_wea,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        bus_err,
    output logic [1:0]  dbgState
);

    // Handshake: a request is accepted in any cycle where bus_req=1 and bus_addr_ok=1;
    // the transaction completes in the first cycle after (or with) acceptance where
    // bus_data_ok=1. bus_data_ok outside an accepted transaction carries no meaning.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } stateType;

    localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    stateType       state;
    stateType       nextState;
    logic [WDW-1:0] wdCnt;
    logic           capture;
    logic           abort;
    logic           wdExpired;
    logic           startReq;

    assign dbgState  = state;
    assign startReq  = (state == IDLE) && cpu_en;
    // The counter holds cycles already spent in REQ/WAIT, so WD_LAST marks the final allowed one.
    assign wdExpired = (TIMEOUT != 0) && (wdCnt == WD_LAST);

    always_comb begin
        nextState = state;
        capture   = 1'b0;
        abort     = 1'b0;
        cpu_stall = 1'b0;
        bus_req   = 1'b0;
        case (state)
            IDLE: begin
                cpu_stall = cpu_en;
                if (cpu_en) begin
                    nextState = REQ;
                end
            end
            REQ: begin
                bus_req   = 1'b1;
                cpu_stall = 1'b1;
                if (bus_addr_ok && bus_data_ok) begin
                    capture   = 1'b1;
                    nextState = DONE;
                end else if (wdExpired) begin
                    abort     = 1'b1;
                    nextState = DONE;
                end else if (bus_addr_ok) begin
                    nextState = WAIT;
                end
            end
            WAIT: begin
                cpu_stall = 1'b1;
                if (bus_data_ok) begin
                    capture   = 1'b1;
                    nextState = DONE;
                end else if (wdExpired) begin
                    abort     = 1'b1;
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
        if (!reset) begin
            cpu_stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cpu_rdata <= '0;
            bus_wr    <= 1'b0;
            bus_wstrb <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_err   <= 1'b0;
            wdCnt     <= '0;
        end else begin
            state <= nextState;
            if (startReq) begin
                bus_addr  <= cpu_addr;
                bus_wdata <= cpu_wdata;
                bus_wstrb <= cpu_wea;
                bus_wr    <= |cpu_wea;
                wdCnt     <= '0;
            end else if ((state == REQ) || (state == WAIT)) begin
                wdCnt <= wdCnt + WDW'(1);
            end
            if (capture && !bus_wr) begin
                cpu_rdata <= bus_rdata;
            end
            // An aborted load returns zero so the core never consumes stale data.
            if (abort) begin
                bus_err <= 1'b1;
                if (!bus_wr) begin
                    cpu_rdata <= '0;
                end
            end
        end
    end

endmodule
